// File: rtl/cpu_run_ctrl_pkg.sv
// Shared types for the CPU run controller: FSM state encoding and helpers.
package cpu_run_ctrl_pkg;

  localparam int RUN_STATE_W = 3;

  typedef enum logic [RUN_STATE_W-1:0] {
    ST_IDLE  = 3'd0,
    ST_RESET = 3'd1,
    ST_RUN   = 3'd2,
    ST_PAUSE = 3'd3,
    ST_STEP  = 3'd4,
    ST_DONE  = 3'd5
  } run_state_t;

  // States in which the CPU actually advances one cycle.
  function automatic logic state_executes(run_state_t s);
    return (s == ST_RUN) || (s == ST_STEP);
  endfunction

endpackage

// File: rtl/cpu_run_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear; also exposes the value it
// would take on an enabled cycle so callers can compare before it lands.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         clr_i,
  input  logic         en_i,
  output logic [W-1:0] count_o,
  output logic [W-1:0] count_inc_o
);

  logic [W-1:0] count_q, count_d;

  assign count_inc_o = (&count_q) ? count_q : count_q + W'(1);
  assign count_o     = count_q;

  always_comb begin
    count_d = count_q;
    if (clr_i)     count_d = '0;
    else if (en_i) count_d = count_inc_o;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) count_q <= '0;
    else         count_q <= count_d;
  end

endmodule

// File: rtl/cpu_run_ctrl.sv
// Run controller for the single-cycle core: reset sequencing, free-run or
// single-step execution gating, cycle counting, tohost and timeout detection.
module cpu_run_ctrl
  import cpu_run_ctrl_pkg::*;
#(
  parameter int               XLEN         = 32,
  parameter int               RESET_CYCLES = 4,
  parameter int               MAX_CYCLES   = 1000,
  parameter int               CNT_W        = 32,
  parameter logic [XLEN-1:0]  TOHOST_ADDR  = 32'h0000_00FC,
  parameter logic [XLEN-1:0]  PASS_CODE    = 32'h1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             step_mode,
  input  logic             step,
  input  logic             mem_we,
  input  logic [XLEN-1:0]  mem_addr,
  input  logic [XLEN-1:0]  mem_wdata,
  output logic             cpu_rst,
  output logic             cpu_en,
  output logic             done,
  output logic             pass,
  output logic             timeout,
  output logic [XLEN-1:0]  result,
  output logic [CNT_W-1:0] cycles,
  output logic             busy
);

  localparam int                RCNT_W    = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
  localparam logic [RCNT_W-1:0] RCNT_LOAD = RCNT_W'(RESET_CYCLES - 1);
  localparam logic [CNT_W-1:0]  MAX_CNT   = CNT_W'(MAX_CYCLES);

  run_state_t        state_q, state_d;
  logic [RCNT_W-1:0] rcnt_q, rcnt_d;
  logic [XLEN-1:0]   result_q, result_d;
  logic              done_q, done_d;
  logic              pass_q, pass_d;
  logic              timeout_q, timeout_d;
  logic [CNT_W-1:0]  cyc_inc;
  logic              start_acc, tohost_hit, budget_hit;

  assign start_acc  = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
  assign tohost_hit = cpu_en && mem_we && (mem_addr == TOHOST_ADDR);
  // A tohost store in the same cycle as budget expiry takes precedence.
  assign budget_hit = cpu_en && (cyc_inc == MAX_CNT) && !tohost_hit;

  sat_counter #(.W(CNT_W)) u_cycles (
    .clk_i       (clk),
    .rst_ni      (rst),
    .clr_i       (start_acc),
    .en_i        (cpu_en),
    .count_o     (cycles),
    .count_inc_o (cyc_inc)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      rcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      rcnt_q  <= rcnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    rcnt_d  = rcnt_q;
    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d = ST_RESET;
          rcnt_d  = RCNT_LOAD;
        end
      end
      ST_RESET: begin
        if (rcnt_q == '0) state_d = step_mode ? ST_PAUSE : ST_RUN;
        else              rcnt_d  = rcnt_q - 1'b1;
      end
      ST_RUN: begin
        if (tohost_hit || budget_hit) state_d = ST_DONE;
      end
      ST_PAUSE: begin
        if (step)            state_d = ST_STEP;
        else if (!step_mode) state_d = ST_RUN;
      end
      ST_STEP: begin
        state_d = (tohost_hit || budget_hit) ? ST_DONE : ST_PAUSE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    cpu_rst = (state_q == ST_IDLE) || (state_q == ST_RESET);
    cpu_en  = state_executes(state_q);
    busy    = (state_q == ST_RESET) || (state_q == ST_RUN) ||
              (state_q == ST_PAUSE) || (state_q == ST_STEP);
  end

  always_comb begin
    result_d  = result_q;
    done_d    = done_q;
    pass_d    = pass_q;
    timeout_d = timeout_q;
    if (start_acc) begin
      result_d  = '0;
      done_d    = 1'b0;
      pass_d    = 1'b0;
      timeout_d = 1'b0;
    end else if (tohost_hit) begin
      result_d  = mem_wdata;
      done_d    = 1'b1;
      pass_d    = (mem_wdata == PASS_CODE);
      timeout_d = 1'b0;
    end else if (budget_hit) begin
      done_d    = 1'b1;
      pass_d    = 1'b0;
      timeout_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      result_q  <= '0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      result_q  <= result_d;
      done_q    <= done_d;
      pass_q    <= pass_d;
      timeout_q <= timeout_d;
    end
  end

  assign result  = result_q;
  assign done    = done_q;
  assign pass    = pass_q;
  assign timeout = timeout_q;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Bench for cpu_run_ctrl: the bench plays the CPU program and checks run
// outcomes against a run-level reference model.
module tb_cpu_run_ctrl;

  localparam int          R      = 4;
  localparam int          MAXC   = 50;
  localparam logic [31:0] TOHOST = 32'h0000_00FC;

  logic        clk, rst, start, step_mode, step, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic        cpu_rst, cpu_en, done, pass, timeout, busy;
  logic [31:0] result;
  logic [31:0] cycles;

  int n_checks = 0;
  int n_fail   = 0;

  cpu_run_ctrl #(
    .XLEN(32), .RESET_CYCLES(R), .MAX_CYCLES(MAXC), .CNT_W(32),
    .TOHOST_ADDR(TOHOST), .PASS_CODE(32'h1)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .step_mode(step_mode), .step(step),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .cpu_rst(cpu_rst), .cpu_en(cpu_en), .done(done), .pass(pass),
    .timeout(timeout), .result(result), .cycles(cycles), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    logic        done;
    logic        pass;
    logic        to;
    logic [31:0] res;
  } exp_t;

  // Outcome of a free run whose program does one store in enabled cycle st_cyc.
  function automatic exp_t model(input int st_cyc, input logic [31:0] addr,
                                 input logic [31:0] data);
    exp_t e;
    bit hit;
    hit    = (addr == TOHOST) && (st_cyc >= 1) && (st_cyc <= MAXC);
    e.done = 1'b1;
    e.cyc  = hit ? st_cyc : MAXC;
    e.to   = !hit;
    e.res  = hit ? data : 32'h0;
    e.pass = hit && (data == 32'h1);
    return e;
  endfunction

  // Starts a free run and acts as the CPU until done or the cycle bound.
  task automatic do_run(input int st_cyc, input logic [31:0] st_addr,
                        input logic [31:0] st_data, input int poke,
                        output int rst_cnt, output int en_cnt, output int first_en,
                        output bit clr_ok, output bit hung);
    rst_cnt = 0; en_cnt = 0; first_en = -1; hung = 1'b1;
    step_mode = 1'b0; mem_we = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start  = 1'b0;
    clr_ok = (done === 1'b0) && (pass === 1'b0) && (timeout === 1'b0) &&
             (cycles === 32'h0) && (result === 32'h0);
    for (int i = 0; i < 200; i++) begin
      if (done === 1'b1) begin
        hung = 1'b0;
        break;
      end
      if (cpu_rst) rst_cnt++;
      if (cpu_en) begin
        en_cnt++;
        if (first_en < 0) first_en = i;
        mem_we    = (en_cnt == st_cyc);
        mem_addr  = st_addr;
        mem_wdata = st_data;
        start     = (poke != 0) && (en_cnt == poke);
      end else begin
        start     = 1'b0;
        mem_we    = 1'($urandom_range(0, 1));
        mem_addr  = TOHOST;
        mem_wdata = $urandom;
      end
      @(posedge clk); #1;
    end
    mem_we = 1'b0;
    start  = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if ({cpu_rst, cpu_en, done, pass, timeout, busy} !== 6'b100000) begin
      n_fail++;
      $display("FAIL reset_flags: got %b expected 100000",
               {cpu_rst, cpu_en, done, pass, timeout, busy});
    end
    n_checks++;
    if (result !== 32'h0 || cycles !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_data: result=%0h cycles=%0d expected 0/0", result, cycles);
    end
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if ({cpu_rst, cpu_en, busy} !== 3'b100) begin
      n_fail++;
      $display("FAIL idle_after_reset: got %b expected 100", {cpu_rst, cpu_en, busy});
    end
  endtask

  task automatic test_basic_pass;
    int rc, ec, fe;
    bit co, hg;
    exp_t e;
    e = model(10, TOHOST, 32'h1);
    do_run(10, TOHOST, 32'h1, 0, rc, ec, fe, co, hg);
    n_checks++;
    if (hg || rc != R || fe != R) begin
      n_fail++;
      $display("FAIL basic_timing: hung=%0d rst_cycles=%0d first_en=%0d expected 0/%0d/%0d",
               hg, rc, fe, R, R);
    end
    n_checks++;
    if ({done, pass, timeout} !== {e.done, e.pass, e.to} || result !== e.res ||
        cycles !== 32'(e.cyc) || ec != e.cyc) begin
      n_fail++;
      $display("FAIL basic_result: dpt=%b res=%0h cyc=%0d en=%0d expected %b/%0h/%0d",
               {done, pass, timeout}, result, cycles, ec, {e.done, e.pass, e.to}, e.res, e.cyc);
    end
    ec = 0;
    repeat (5) begin
      mem_we = 1'b1; mem_addr = TOHOST; mem_wdata = 32'h55;
      @(posedge clk); #1;
      if (cpu_en) ec++;
    end
    mem_we = 1'b0;
    n_checks++;
    if (ec != 0 || cycles !== 32'd10 || result !== 32'h1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL done_frozen: en=%0d cycles=%0d result=%0h busy=%b expected 0/10/1/0",
               ec, cycles, result, busy);
    end
  endtask

  task automatic test_reset_midrun;
    step_mode = 1'b0; mem_we = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (R + 20) @(posedge clk);
    #1;
    n_checks++;
    if (cycles !== 32'd20 || cpu_en !== 1'b1) begin
      n_fail++;
      $display("FAIL midrun_progress: cycles=%0d cpu_en=%b expected 20/1", cycles, cpu_en);
    end
    #2 rst = 1'b0;
    #1;
    n_checks++;
    if ({cpu_rst, cpu_en, done, pass, timeout, busy} !== 6'b100000 ||
        result !== 32'h0 || cycles !== 32'h0) begin
      n_fail++;
      $display("FAIL midrun_reset: flags=%b result=%0h cycles=%0d expected 100000/0/0",
               {cpu_rst, cpu_en, done, pass, timeout, busy}, result, cycles);
    end
    @(posedge clk); #3;
    rst = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if ({cpu_rst, cpu_en, busy} !== 3'b100) begin
      n_fail++;
      $display("FAIL midrun_idle: got %b expected 100", {cpu_rst, cpu_en, busy});
    end
  endtask

  task automatic test_store(input string name, input int st, input logic [31:0] addr,
                            input logic [31:0] data);
    int rc, ec, fe;
    bit co, hg;
    exp_t e;
    e = model(st, addr, data);
    do_run(st, addr, data, 0, rc, ec, fe, co, hg);
    n_checks++;
    if (hg || {done, pass, timeout} !== {e.done, e.pass, e.to} || result !== e.res ||
        cycles !== 32'(e.cyc) || ec != e.cyc) begin
      n_fail++;
      $display("FAIL %s: hung=%0d dpt=%b res=%0h cyc=%0d en=%0d expected %b/%0h/%0d",
               name, hg, {done, pass, timeout}, result, cycles, ec,
               {e.done, e.pass, e.to}, e.res, e.cyc);
    end
  endtask

  task automatic test_restart;
    int rc, ec, fe, rc2, ec2, fe2;
    bit co, hg, co2, hg2;
    logic [31:0] cyc1, res1;
    do_run(10, TOHOST, 32'h1, 0, rc, ec, fe, co, hg);
    cyc1 = cycles; res1 = result;
    do_run(10, TOHOST, 32'h1, 5, rc2, ec2, fe2, co2, hg2);
    n_checks++;
    if (!co2) begin
      n_fail++;
      $display("FAIL restart_clear: flags not cleared after start in DONE (got 0, expected 1)");
    end
    n_checks++;
    if (hg2 || rc2 != R || cycles !== cyc1 || result !== res1 || cycles !== 32'd10) begin
      n_fail++;
      $display("FAIL restart_rerun: hung=%0d rst_cycles=%0d cycles=%0d result=%0h expected 0/%0d/10/%0h",
               hg2, rc2, cycles, result, R, res1);
    end
  endtask

  task automatic test_step;
    int en_tot, bad;
    bit seen;
    en_tot = 0; bad = 0;
    mem_we = 1'b0; step_mode = 1'b1; step = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < R + 3; i++) begin
      if (cpu_en) en_tot++;
      @(posedge clk); #1;
    end
    n_checks++;
    if (en_tot != 0 || {cpu_rst, cpu_en, busy} !== 3'b001) begin
      n_fail++;
      $display("FAIL step_pause: en=%0d rst/en/busy=%b expected 0/001", en_tot, {cpu_rst, cpu_en, busy});
    end
    for (int p = 0; p < 3; p++) begin
      step = 1'b1;
      @(posedge clk); #1;
      step = 1'b0;
      if (cpu_en) en_tot++;
      for (int j = 0; j < 4; j++) begin
        @(posedge clk); #1;
        if (cpu_en) en_tot++;
        if ({cpu_rst, cpu_en, busy} !== 3'b001) bad++;
      end
    end
    n_checks++;
    if (en_tot != 3 || cycles !== 32'd3 || bad != 0) begin
      n_fail++;
      $display("FAIL step_pulses: en=%0d cycles=%0d non_pause=%0d expected 3/3/0", en_tot, cycles, bad);
    end
    step = 1'b1;
    for (int j = 0; j < 6; j++) begin
      @(posedge clk); #1;
      if (cpu_en) en_tot++;
    end
    step = 1'b0;
    @(posedge clk); #1;
    if (cpu_en) en_tot++;
    n_checks++;
    if (en_tot != 6 || cycles !== 32'd6) begin
      n_fail++;
      $display("FAIL step_held: en=%0d cycles=%0d expected 6/6", en_tot, cycles);
    end
    step_mode = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      if (done === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    n_checks++;
    if (!seen || {timeout, pass} !== 2'b10 || cycles !== 32'(MAXC)) begin
      n_fail++;
      $display("FAIL step_to_run: done=%b to/pass=%b cycles=%0d expected 1/10/%0d",
               seen, {timeout, pass}, cycles, MAXC);
    end
  endtask

  task automatic test_random;
    int st, sel;
    logic [31:0] addr, data;
    for (int n = 0; n < 10; n++) begin
      st   = $urandom_range(1, 60);
      sel  = $urandom_range(0, 2);
      addr = (sel == 0) ? TOHOST :
             (sel == 1) ? 32'h0000_00F8 : (($urandom & 32'hFFFF_FF00) | 32'h0000_1000);
      data = ($urandom_range(0, 1) == 1) ? 32'h1 : $urandom;
      test_store("random_run", st, addr, data);
    end
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; step_mode = 1'b0; step = 1'b0;
    mem_we = 1'b0; mem_addr = '0; mem_wdata = '0;
    @(posedge clk); #1;
    test_reset();
    test_basic_pass();
    test_reset_midrun();
    test_store("bad_code", 7, TOHOST, 32'h0000_0BAD);
    test_store("wrong_addr_timeout", 10, 32'h0000_00F8, 32'h1);
    test_store("tohost_on_last_cycle", MAXC, TOHOST, 32'h1);
    test_restart();
    test_step();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/cpu_run_ctrl.md
# cpu_run_ctrl

Parametrised run controller for the single-cycle RISC-V core: sequences the CPU's reset, gates execution with a clock enable, and supports free-run or single-step modes. It counts executed cycles, detects end-of-test through a store to a `tohost` address, and enforces a cycle timeout. It sits between the top level (board or bench) and `cpu`, replacing fixed-delay reset and `$finish` control with synthesizable, observable run control.

## Interface
- `XLEN`, 32: data/address width of the monitored store bus.
- `RESET_CYCLES`, 4: cycles `cpu_rst` is held after `start`; must be ≥1.
- `MAX_CYCLES`, 1000: executed-cycle budget before timeout; must be ≥1.
- `CNT_W`, 32: cycle counter width.
- `TOHOST_ADDR`, 32'h0000_00FC: store address that ends the test.
- `PASS_CODE`, 32'h1: `tohost` value meaning pass.
- `clk`  input  1  single clock, rising edge.
- `rst`  input  1  asynchronous, active-low reset of this block.
- `start`  input  1  one-cycle pulse that begins a run; ignored outside IDLE/DONE.
- `step_mode`  input  1  1 = single-step, 0 = free-run; sampled when leaving RESET.
- `step`  input  1  pulse in PAUSE that executes exactly one CPU cycle.
- `mem_we`  input  1  CPU data-memory write enable.
- `mem_addr`  input  XLEN  CPU data-memory address.
- `mem_wdata`  input  XLEN  CPU data-memory write data.
- `cpu_rst`  output  1  active-high reset to `cpu`.
- `cpu_en`  output  1  CPU clock enable; PC/regfile/memory update only when 1.
- `done`  output  1  run finished (tohost or timeout).
- `pass`  output  1  `done` and `result == PASS_CODE`.
- `timeout`  output  1  run ended by cycle budget.
- `result`  output  XLEN  captured `tohost` data.
- `cycles`  output  CNT_W  executed (enabled) cycle count.
- `busy`  output  1  state is RESET, RUN, PAUSE or STEP.

## Operation
- States: IDLE, RESET, RUN, PAUSE, STEP, DONE.
- IDLE: `cpu_rst`=1, `cpu_en`=0. `start` clears `cycles`, `result`, `pass`, `timeout`, and `done`, loads the reset counter, and moves to RESET.
- RESET: `cpu_rst`=1 for exactly RESET_CYCLES cycles. The next state is PAUSE if `step_mode`=1, otherwise RUN.
- RUN: `cpu_rst`=0, `cpu_en`=1 every cycle.
- PAUSE: `cpu_en`=0, `cpu_rst`=0. `step` moves to STEP. `step_mode` sampled 0 in PAUSE moves to RUN.
- STEP: `cpu_en`=1 for one cycle, then PAUSE.
- Monitoring happens only in cycles with `cpu_en`=1:
  - `cycles` increments and saturates at all-ones.
  - `mem_we && mem_addr==TOHOST_ADDR` captures `mem_wdata` into `result` and goes to DONE, with `pass` = (`mem_wdata==PASS_CODE`).
  - If the incremented `cycles` equals MAX_CYCLES and there is no tohost store in that cycle: `timeout`=1, `pass`=0, go to DONE.
- Simultaneous tohost store and budget expiry: the tohost result wins and `timeout`=0.
- DONE: `cpu_en`=0, `cpu_rst`=0 (CPU state is frozen for inspection). All result outputs hold. `start` re-enters RESET with all flags cleared.
- Stores to `TOHOST_ADDR` while `cpu_en`=0 are ignored.

## Timing
- Reset (`rst`=0) forces state IDLE, `cpu_rst`=1, `cpu_en`=0, `done`=`pass`=`timeout`=`busy`=0, `result`=0, `cycles`=0. This is asynchronous and takes effect mid-run.
- `cpu_rst`, `cpu_en`, and `busy` are decoded combinationally from registered state. `done`, `pass`, `timeout`, `result`, and `cycles` are registered.
- `start` at edge k puts the block in RESET from k+1 to k+RESET_CYCLES. The first `cpu_en`=1 cycle is k+RESET_CYCLES+1 in free-run.
- A tohost store in enabled cycle n gives `done`=1 from n+1. The CPU executes no further cycle after n.
- With no tohost store, `done`/`timeout` rise the cycle after the MAX_CYCLES-th enabled cycle, with `cycles`=MAX_CYCLES.
- `step` pulses held longer than one cycle produce one STEP per PAUSE→STEP transition, i.e. at most one every 2 cycles.

## Structure
- `cpu_run_ctrl_pkg` holds the `run_state_t` enum (6 states, 3 bits) and a `RUN_STATE_W` constant.
- Sub-module `sat_counter` (parameter `W`; ports for clear, enable, and count) is used for `cycles`. The reset countdown is an inline down-counter.
- `cpu` gains `en` gating on its state elements. Tying it to `cpu_rst`/`cpu_en` replaces the bench's fixed-delay reset.

## Test plan
- Reset mid-RUN (`rst`=0 at cycle 20 of a run) → IDLE immediately, all outputs at their reset values, `cpu_rst`=1.
- Free-run, RESET_CYCLES=4, program stores 1 to 0xFC in its 10th enabled cycle → `done`=`pass`=1, `result`=1, `cycles`=10, `timeout`=0, `cpu_en`=0 thereafter.
- Store of 0xBAD to 0xFC → `done`=1, `pass`=0, `result`=0xBAD. A store of 1 to 0xF8 does not end the run.
- Infinite loop, MAX_CYCLES=50 → `timeout`=1, `done`=1, `pass`=0, `cycles`=50. With MAX_CYCLES set to the tohost cycle → tohost wins, `timeout`=0.
- `step_mode`=1 with 3 `step` pulses spaced 5 cycles apart → exactly 3 `cpu_en` cycles, `cycles`=3, state PAUSE between steps.
- `start` in DONE → flags cleared, 4 cycles of `cpu_rst`=1, rerun reproduces identical `cycles`/`result`. `start` during RUN is ignored.
